// File: rtl/corr_scan_controller.sv
// corr_scan_controller: raster template-window scan with best-score tracking and threshold early exit
module corr_scan_controller #(
  parameter int COORD_W  = 13,
  parameter int CORR_W   = 32,
  parameter int FRAME_W  = 640,
  parameter int FRAME_H  = 480,
  parameter int TPL_W    = 32,
  parameter int TPL_H    = 32,
  parameter int MODE_MIN = 0
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFrameDone,
  input  logic [3:0]         iStep,
  input  logic               iThreshEn,
  input  logic [CORR_W-1:0]  iThreshold,
  input  logic               iCorrFinished,
  input  logic [CORR_W-1:0]  iCurrentCorr,
  output logic               oCorrStart,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic [COORD_W-1:0] oXresult,
  output logic [COORD_W-1:0] oYresult,
  output logic [CORR_W-1:0]  oBestCorr,
  output logic               oFound,
  output logic               oFinished,
  output logic               oBusy,
  output logic               oStatusLed
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADVANCE, DONE} state_t;
  localparam logic [COORD_W:0] XMAX = (COORD_W+1)'(FRAME_W - TPL_W);
  localparam logic [COORD_W:0] YMAX = (COORD_W+1)'(FRAME_H - TPL_H);
  state_t state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, bx_q, bx_d, by_q, by_d, xres_q, xres_d, yres_q, yres_d;
  logic [CORR_W-1:0] bs_q, bs_d, bcorr_q, bcorr_d, thr_q, thr_d;
  logic [3:0] step_q, step_d;
  logic thr_en_q, thr_en_d, bv_q, bv_d, start_q, start_d, found_q, found_d;
  logic fin_q, fin_d, busy_q, busy_d, led_q, led_d;
  logic [COORD_W:0] nx, ny;
  logic better, hit;
  // next-state: scan sequencing, best tracking and result publication
  always_comb begin
    nx = {1'b0, x_q} + (COORD_W+1)'(step_q);
    ny = {1'b0, y_q} + (COORD_W+1)'(step_q);
    better = !bv_q || ((MODE_MIN != 0) ? (iCurrentCorr < bs_q) : (iCurrentCorr > bs_q));
    hit = thr_en_q && ((MODE_MIN != 0) ? (iCurrentCorr <= thr_q) : (iCurrentCorr >= thr_q));
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    bx_d = bx_q;
    by_d = by_q;
    bs_d = bs_q;
    bv_d = bv_q;
    xres_d = xres_q;
    yres_d = yres_q;
    bcorr_d = bcorr_q;
    thr_d = thr_q;
    thr_en_d = thr_en_q;
    step_d = step_q;
    start_d = 1'b0;
    found_d = found_q;
    fin_d = fin_q;
    busy_d = busy_q;
    led_d = led_q;
    case (state_q)
      IDLE: if (iFrameDone) begin
        step_d = (iStep == 4'd0) ? 4'd1 : iStep;
        thr_d = iThreshold;
        thr_en_d = iThreshEn;
        x_d = '0;
        y_d = '0;
        bv_d = 1'b0;
        fin_d = 1'b0;
        found_d = 1'b0;
        busy_d = 1'b1;
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (iCorrFinished) begin
        if (better || hit) begin
          bx_d = x_q;
          by_d = y_q;
          bs_d = iCurrentCorr;
          bv_d = 1'b1;
        end
        found_d = hit;
        state_d = hit ? DONE : ADVANCE;
      end
      ADVANCE: begin
        x_d = (nx <= XMAX) ? nx[COORD_W-1:0] : '0;
        y_d = (nx > XMAX && ny <= YMAX) ? ny[COORD_W-1:0] : y_q;
        state_d = (nx > XMAX && ny > YMAX) ? DONE : ISSUE;
        start_d = !(nx > XMAX && ny > YMAX);
      end
      DONE: begin
        xres_d = bx_q;
        yres_d = by_q;
        bcorr_d = bs_q;
        fin_d = 1'b1;
        busy_d = 1'b0;
        led_d = !led_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // register all state and outputs; reset abandons any scan in progress
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      bs_q <= '0;
      bv_q <= 1'b0;
      xres_q <= '0;
      yres_q <= '0;
      bcorr_q <= '0;
      thr_q <= '0;
      thr_en_q <= 1'b0;
      step_q <= '0;
      start_q <= 1'b0;
      found_q <= 1'b0;
      fin_q <= 1'b0;
      busy_q <= 1'b0;
      led_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      bx_q <= bx_d;
      by_q <= by_d;
      bs_q <= bs_d;
      bv_q <= bv_d;
      xres_q <= xres_d;
      yres_q <= yres_d;
      bcorr_q <= bcorr_d;
      thr_q <= thr_d;
      thr_en_q <= thr_en_d;
      step_q <= step_d;
      start_q <= start_d;
      found_q <= found_d;
      fin_q <= fin_d;
      busy_q <= busy_d;
      led_q <= led_d;
    end
  end
  assign oCorrStart = start_q;
  assign oX = x_q;
  assign oY = y_q;
  assign oXresult = xres_q;
  assign oYresult = yres_q;
  assign oBestCorr = bcorr_q;
  assign oFound = found_q;
  assign oFinished = fin_q;
  assign oBusy = busy_q;
  assign oStatusLed = led_q;
endmodule

// File: doc/corr_scan_controller.md
Name: corr_scan_controller

Overview:
Parametrised template-match scan controller, successor to the fixed-size camera correlation controller. On each frame-done it steps a template window over the frame in raster order, issuing one correlation request per position. It waits for the correlator's result, tracks the best score (max or min mode, configured by parameter) and reports the winning coordinates. It adds runtime step size, optional threshold early-exit, a busy flag and an explicit request strobe.

Parameters:
COORD_W, 13, coordinate width; must hold FRAME_W-1 and FRAME_H-1
CORR_W, 32, correlation score width (unsigned)
FRAME_W, 640, frame width in pixels
FRAME_H, 480, frame height in pixels
TPL_W, 32, template width; TPL_W <= FRAME_W
TPL_H, 32, template height; TPL_H <= FRAME_H
MODE_MIN, 0, 0 = higher score is better (correlation); 1 = lower score is better (SAD)

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous reset, active-high
iFrameDone  in  1  start a scan; sampled only in IDLE
iStep  in  4  scan stride in pixels, latched at start; 0 is treated as 1
iThreshEn  in  1  enable early exit, latched at start
iThreshold  in  CORR_W  early-exit threshold, latched at start
iCorrFinished  in  1  correlator result valid; sampled only in WAIT
iCurrentCorr  in  CORR_W  score for the current oX/oY
oCorrStart  out  1  one-cycle request to the correlator for oX/oY
oX  out  COORD_W  current window top-left X
oY  out  COORD_W  current window top-left Y
oXresult  out  COORD_W  best X of the last completed scan
oYresult  out  COORD_W  best Y of the last completed scan
oBestCorr  out  CORR_W  best score of the last completed scan
oFound  out  1  last scan ended on a threshold hit
oFinished  out  1  sticky scan-complete flag
oBusy  out  1  scan in progress
oStatusLed  out  1  toggles at each completed scan

Behaviour:
- Reset: state IDLE. All outputs are 0, the internal best score is 0 and best-valid is 0.
- XMAX = FRAME_W-TPL_W and YMAX = FRAME_H-TPL_H. Position arithmetic uses COORD_W+1 bits, so there is no silent wrap.
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE. Every output is registered.
- IDLE: oBusy=0. When iFrameDone=1:
  - latch the step, threshold and threshold-enable;
  - set oX=oY=0;
  - clear best-valid, oFinished and oFound; set oBusy=1;
  - go to ISSUE.
- ISSUE: oCorrStart=1 for exactly this cycle; go to WAIT. First oCorrStart is 1 cycle after the cycle that samples iFrameDone.
- WAIT: hold oX/oY. When iCorrFinished=1, compare the score:
  - The sample becomes best if best-valid=0, or if it is strictly better (> when MODE_MIN=0, < when MODE_MIN=1). Ties keep the earlier raster position.
  - A threshold hit requires iThreshEn and a score >= threshold (MODE_MIN=0) or <= threshold (MODE_MIN=1). On a hit, best is forced to the current position and score, oFound=1, and the state goes to DONE.
  - Otherwise go to ADVANCE.
  - WAIT has no timeout.
- ADVANCE: compute nx = oX+step.
  - If nx <= XMAX: oX=nx.
  - Else: oX=0 and ny = oY+step. If ny > YMAX go to DONE; otherwise oY=ny.
  - If not going to DONE, go to ISSUE. The next oCorrStart is 2 cycles after the iCorrFinished cycle.
- DONE (1 cycle):
  - oXresult, oYresult and oBestCorr take the best values;
  - oFinished=1, oBusy=0, oStatusLed toggles;
  - go to IDLE.
  - oFinished, oFound and the result outputs hold until the next accepted iFrameDone. Starting a new scan clears oFinished and oFound only; the results hold until that scan's DONE.
- Ignored inputs: iFrameDone while busy; iCorrFinished outside WAIT, including the ISSUE cycle.
- Changes to iStep, iThreshold or iThreshEn mid-scan have no effect.
- iRST mid-scan: returns to the reset state immediately and abandons the scan. No partial results are published.
- TPL equal to frame size gives XMAX=YMAX=0, so exactly one position is scanned.

Test Plan:
- FRAME 8x6, TPL 4x4, iStep=2, MODE_MIN=0, scores 5,9,3,9,1,2 -> positions (0,0),(2,0),(4,0),(0,2),(2,2),(4,2) -> 6 oCorrStart pulses, oXresult=2, oYresult=0, oBestCorr=9 (tie keeps first), oFinished=1, oFound=0.
- Same frame with MODE_MIN=1, scores 5,9,3,9,1,2 -> oXresult=2, oYresult=2, oBestCorr=1.
- Threshold early exit: iThreshEn=1, iThreshold=8, scores 5,9 -> stops after 2 requests, oXresult=2, oYresult=0, oFound=1, no third oCorrStart.
- iStep=0 with FRAME 6x5, TPL 4x4 -> 3x2=6 positions at stride 1, last position (2,1); iFrameDone pulsed during the scan has no effect.
- iRST asserted in WAIT after 3 results -> next cycle all outputs 0 and state IDLE. A fresh scan then completes normally; a stray iCorrFinished during ISSUE is ignored.
- FRAME=TPL=4x4 -> exactly 1 request at (0,0); oStatusLed toggles from 0 to 1.
